// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD timing generator: FSM states,
// timing presets for common panels and the colour-bar table.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lcd_state_e;

    typedef struct packed {
        logic [11:0] sync;
        logic [11:0] back;
        logic [11:0] disp;
        logic [11:0] front;
    } lcd_axis_t;

    localparam lcd_axis_t H_480X272  = '{12'd4,   12'd23,  12'd480,  12'd13};
    localparam lcd_axis_t V_480X272  = '{12'd4,   12'd15,  12'd272,  12'd9};
    localparam lcd_axis_t H_800X480  = '{12'd48,  12'd88,  12'd800,  12'd40};
    localparam lcd_axis_t V_800X480  = '{12'd3,   12'd32,  12'd480,  12'd13};
    localparam lcd_axis_t H_1024X768 = '{12'd136, 12'd160, 12'd1024, 12'd24};
    localparam lcd_axis_t V_1024X768 = '{12'd6,   12'd29,  12'd768,  12'd3};
    localparam lcd_axis_t H_1280X720 = '{12'd40,  12'd220, 12'd1280, 12'd110};
    localparam lcd_axis_t V_1280X720 = '{12'd5,   12'd20,  12'd720,  12'd5};

    // Index 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic int axis_total(input lcd_axis_t a);
        return int'(a.sync) + int'(a.back) + int'(a.disp) + int'(a.front);
    endfunction

endpackage

// File: rtl/lcd_timing_gen_pattern.sv
// Colour-bar pattern: maps an active-area column to one of eight bars.
// Only instantiated when LCD_TEST_PATTERN_EN is defined.
module lcd_pattern_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_DISP = 480
) (
    input  logic [11:0] x_i,
    output logic [23:0] rgb_o
);

    localparam int BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;

    logic [7:1] past_edge;
    logic [2:0] bar_idx;

    genvar gi;
    for (gi = 1; gi < 8; gi++) begin : g_edge
        assign past_edge[gi] = ({20'd0, x_i} >= 32'(gi * BAR_W));
    end

    // Columns beyond the eighth edge (H_DISP not a multiple of 8) stay black.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (past_edge[i]) bar_idx = 3'(i);
        end
        rgb_o = BAR_RGB[bar_idx];
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parallel RGB LCD timing generator with look-ahead pixel requests.
// Define LCD_TEST_PATTERN_EN to build in the colour-bar test pattern.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int          H_SYNC   = 4,
    parameter int          H_BACK   = 23,
    parameter int          H_DISP   = 480,
    parameter int          H_FRONT  = 13,
    parameter int          V_SYNC   = 4,
    parameter int          V_BACK   = 15,
    parameter int          V_DISP   = 272,
    parameter int          V_FRONT  = 9,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int          PIX_LEAD = 1,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        test_mode,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        lcd_clk,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_cnt,
    output logic        underflow
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_err_total
        $error("lcd_timing_gen: H_TOTAL or V_TOTAL exceeds 4095");
    end
    if (PIX_LEAD < 1 || PIX_LEAD > 4) begin : g_err_lead
        $error("lcd_timing_gen: PIX_LEAD must be 1..4");
    end

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_E  = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_E  = 12'(V_SYNC);
    localparam logic [11:0] H_ACT0    = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] V_ACT0    = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] H_ACT_END = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BACK + V_DISP);

    lcd_state_e  state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic        fs_q, fs_d, ls_q, ls_d;
    logic        req_q, req_d;
    logic [11:0] px_q, px_d, py_q, py_d;
    logic [23:0] rgb_q, rgb_d;
    logic        uf_q, uf_d;

    logic        running, h_wrap, v_last, frame_end;
    logic        de_act, req_act;
    logic [12:0] la_h_sum;
    logic        la_h_wrap;
    logic [11:0] la_h, la_v;
    logic        use_pat;
    logic [23:0] pat_rgb;

    function automatic logic in_h(input logic [11:0] h);
        return (h >= H_ACT0) && (h < H_ACT_END);
    endfunction

    function automatic logic in_v(input logic [11:0] v);
        return (v >= V_ACT0) && (v < V_ACT_END);
    endfunction

`ifdef LCD_TEST_PATTERN_EN
    logic [11:0] cur_x;
    assign cur_x   = hcnt_q - H_ACT0;
    assign use_pat = test_mode;

    lcd_pattern_gen #(
        .H_DISP (H_DISP)
    ) u_pattern (
        .x_i   (cur_x),
        .rgb_o (pat_rgb)
    );
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign use_pat          = 1'b0;
    assign pat_rgb          = 24'h000000;
`endif

    assign running   = (state_q != ST_IDLE);
    assign h_wrap    = (hcnt_q == H_LAST);
    assign v_last    = (vcnt_q == V_LAST);
    assign frame_end = running && h_wrap && v_last;

    // Requests are decoded from the raster position PIX_LEAD clocks ahead,
    // so the returned data lands exactly on the matching lcd_de cycle.
    assign la_h_sum  = {1'b0, hcnt_q} + 13'(PIX_LEAD);
    assign la_h_wrap = (la_h_sum >= 13'(H_TOTAL));
    assign la_h      = la_h_wrap ? 12'(la_h_sum - 13'(H_TOTAL)) : la_h_sum[11:0];
    assign la_v      = la_h_wrap ? (v_last ? 12'd0 : vcnt_q + 12'd1) : vcnt_q;

    assign de_act  = running && in_h(hcnt_q) && in_v(vcnt_q);
    assign req_act = running && in_h(la_h) && in_v(la_v);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (en)             state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        hcnt_d = 12'd0;
        vcnt_d = 12'd0;
        if (running) begin
            hcnt_d = h_wrap ? 12'd0 : hcnt_q + 12'd1;
            vcnt_d = vcnt_q;
            if (h_wrap) vcnt_d = v_last ? 12'd0 : vcnt_q + 12'd1;
        end

        frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;

        hs_d = (running && hcnt_q < H_SYNC_E) ? HS_POL : ~HS_POL;
        vs_d = (running && vcnt_q < V_SYNC_E) ? VS_POL : ~VS_POL;
        de_d = de_act;
        ls_d = running && (hcnt_q == 12'd0);
        fs_d = running && (hcnt_q == 12'd0) && (vcnt_q == 12'd0);

        req_d = req_act;
        px_d  = req_act ? la_h - H_ACT0 : 12'd0;
        py_d  = req_act ? la_v - V_ACT0 : 12'd0;

        rgb_d = 24'h000000;
        if (de_act) begin
            if (use_pat)        rgb_d = pat_rgb;
            else if (pix_valid) rgb_d = pix_data;
            else                rgb_d = FILL_RGB;
        end

        uf_d = uf_q;
        if (state_q == ST_IDLE && en)            uf_d = 1'b0;
        else if (de_act && !use_pat && !pix_valid) uf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= 12'd0;
            vcnt_q      <= 12'd0;
            frame_cnt_q <= 16'd0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            ls_q        <= 1'b0;
            req_q       <= 1'b0;
            px_q        <= 12'd0;
            py_q        <= 12'd0;
            rgb_q       <= 24'h000000;
            uf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            ls_q        <= ls_d;
            req_q       <= req_d;
            px_q        <= px_d;
            py_q        <= py_d;
            rgb_q       <= rgb_d;
            uf_q        <= uf_d;
        end
    end

    assign lcd_clk     = clk;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign lcd_rgb     = rgb_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign frame_cnt   = frame_cnt_q;
    assign underflow   = uf_q;
    assign pix_req     = req_q;
    assign pix_x       = px_q;
    assign pix_y       = py_q;

endmodule
